// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake and drives the IF/ID register, inserting NOP bubbles on stall/redirect.
`timescale 1ns/1ps
module instruction_fetch #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Branch,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    output logic                ImemReq,
    output logic [PC_WIDTH-1:0] ImemAddr,
    input  logic                ImemAck,
    input  logic [31:0]         ImemData,
    output logic [31:0]         Instr,
    output logic [PC_WIDTH-1:0] PCPlus4,
    output logic                Valid,
    output logic [5:0]          Op,
    output logic [5:0]          Funct
);

    localparam int unsigned IW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pend_q, pend_d;
    logic [IW-1:0]       hold_q, hold_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [PC_WIDTH-1:0] pcp4_q, pcp4_d;
    logic                valid_q, valid_d;
    logic                req_q, req_d;

    logic [PC_WIDTH-1:0] tgt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                ack;
    logic                tgt_lo_unused;

    assign tgt           = {BranchTarget[PC_WIDTH-1:2], 2'b00};
    assign tgt_lo_unused = ^BranchTarget[1:0];
    assign pc_inc        = pc_q + PC_WIDTH'(4);
    // Acks are only honoured while a request is actually outstanding
    assign ack           = ImemAck & req_q;

    // Next-state and IF/ID update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (Branch) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                    if (ack) begin
                        pc_d = tgt;
                    end else begin
                        // Keep the old PC on the bus until the in-flight read retires
                        pend_d  = tgt;
                        state_d = DRAIN;
                    end
                end else if (ack && !Stall) begin
                    instr_d = ImemData;
                    pcp4_d  = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else if (ack && Stall) begin
                    hold_d  = ImemData;
                    pc_d    = pc_inc;
                    state_d = HOLD;
                end else if (!Stall) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (Branch) begin
                    pc_d    = tgt;
                    instr_d = '0;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!Stall) begin
                    instr_d = hold_q;
                    pcp4_d  = pc_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                instr_d = '0;
                valid_d = 1'b0;
                if (Branch) begin
                    pend_d = tgt;
                end
                if (ack) begin
                    pc_d    = Branch ? tgt : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            hold_q  <= '0;
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign ImemReq  = req_q;
    assign ImemAddr = pc_q;
    assign Instr    = instr_q;
    assign PCPlus4  = pcp4_q;
    assign Valid    = valid_q;
    assign Op       = instr_q[31:26];
    assign Funct    = instr_q[5:0];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the MIPS datapath; producer of the instruction word whose Op/Funct fields feed the main control decoder.
- Owns the PC, issues word reads to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register.
- Honours hazard-unit stalls and branch redirects; bubbles are presented as NOP (all-zero word) so decode emits all-zero control.

Parameters:
- PC_WIDTH, 32, width of PC, addresses and target.
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 00.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard unit: hold IF/ID and PC.
- Branch  input  1  one-cycle redirect request.
- BranchTarget  input  PC_WIDTH  redirect address; bits [1:0] ignored (treated as 00).
- ImemReq  output  1  read request.
- ImemAddr  output  PC_WIDTH  read address; stable while ImemReq=1 until ack.
- ImemAck  input  1  data valid this cycle; meaningful only when ImemReq=1.
- ImemData  input  32  instruction word, sampled when ImemReq&ImemAck.
- Instr  output  32  IF/ID instruction register.
- PCPlus4  output  PC_WIDTH  IF/ID: address of Instr + 4.
- Valid  output  1  IF/ID holds a real instruction.
- Op  output  6  Instr[31:26], combinational from register.
- Funct  output  6  Instr[5:0], combinational from register.

Behaviour:
- Reset (overrides everything, including mid-transaction): PC=RESET_PC, state IDLE, ImemReq=0, Instr=0, PCPlus4=0, Valid=0, Op=0, Funct=0, pending target and hold buffer cleared. Late acks for aborted requests are ignored because ImemReq=0.
- ImemAddr=PC in FETCH/IDLE; in DRAIN it shows the outstanding address. ImemReq=1 only in FETCH and DRAIN.
- Ack may arrive in the same cycle the request is raised, giving a throughput of 1 instruction/cycle.
- IDLE: go to FETCH the cycle after reset is released.
- FETCH, evaluated in priority order:
  - Branch: PC<=target, Instr<=0, Valid<=0. With ack, the data is discarded and the state stays FETCH. Without ack, the target is latched into the pending register, ImemAddr stays on the old PC, and the state goes to DRAIN.
  - Ack & !Stall: Instr<=ImemData, PCPlus4<=PC+4, Valid<=1, PC<=PC+4, stay FETCH.
  - Ack & Stall: ImemData goes to the hold buffer, PC<=PC+4, IF/ID unchanged, go to HOLD.
  - !Ack & Stall: IF/ID unchanged.
  - !Ack & !Stall: bubble (Instr<=0, Valid<=0).
- HOLD (ImemReq=0):
  - Branch: buffer dropped, PC<=target, IF/ID bubble, go to FETCH.
  - !Stall: Instr<=buffer, PCPlus4<=PC, Valid<=1, go to FETCH.
  - Stall: hold.
- DRAIN (request still outstanding, old address):
  - IF/ID stays bubble.
  - A new Branch overwrites the pending target (latest wins).
  - On ack: data discarded, PC<=pending target, or the new BranchTarget if Branch is asserted in the same cycle. Go to FETCH.
- Branch has priority over Stall in every state.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFFFFFC+4 = 0x00000000, and PCPlus4 wraps the same way.
- Latency: ack at cycle n gives Instr/Valid visible at cycle n+1.

Test Plan:
- Reset, then ack tied to 1, with memory returning 0x8C080004, 0x01095020, 0x1109FFFE:
  - ImemAddr must be 0, 4, 8 on consecutive cycles.
  - Next cycles: Op=0x23, then Op=0x00/Funct=0x20, then Op=0x04; PCPlus4 = 4, 8, 12; Valid=1 throughout.
- Ack delayed 2 cycles at address 4:
  - ImemAddr holds 4 and ImemReq holds 1.
  - Valid=0 and Instr=0 during the wait.
  - The instruction appears the cycle after the ack.
- Stall=1 on the ack cycle for address 8, held 3 cycles:
  - ImemReq=0 and IF/ID holds the address-4 instruction.
  - After the stall drops, the address-8 word appears with PCPlus4=12, and the next request goes to 12.
- Branch=1 with target 0x40 while address 8 is waiting:
  - ImemAddr stays 8 until ack, and that data is never presented.
  - The next request goes to 0x40 and Valid=0 meanwhile.
  - Repeat with a second Branch to 0x80 during DRAIN: the request goes to 0x80.
- Branch and Stall asserted together in HOLD:
  - The hold buffer is discarded, and the next ImemAddr is the target with its low bits zeroed (target 0x43 gives 0x40).
- Further checks:
  - reset asserted mid-wait with a late ack: outputs at reset values and the late ack is ignored.
  - RESET_PC=0xFFFFFFFC: the second fetch goes to 0x00000000 and PCPlus4=0.
